// File: rtl/max_pool_row_packer_if.sv
// Row-word valid/ready bus from the pooling row packer to the dense/readout stage.
// Producer drives the head row word and its row index; consumer drives ready.
interface max_pool_row_packer_if #(
  parameter int unsigned OUT_W = 13,
  parameter int unsigned OUT_H = 13
) ();
  localparam int unsigned IDX_W = $clog2(OUT_H);

  logic             row_valid;
  logic             row_ready;
  logic [OUT_W-1:0] row_data;
  logic [IDX_W-1:0] row_idx;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    output row_ready
  );
endinterface

// File: rtl/max_pool_row_packer.sv
// Reduces 2x2 binary windows to pooled bits (OR), packs them into row words and
// queues completed rows in a small FIFO; flags dropped rows and pulses on frame end.
module max_pool_row_packer #(
  parameter int unsigned OUT_W      = 13,
  parameter int unsigned OUT_H      = 13,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_in,
  input  logic pixel_0,
  input  logic pixel_1,
  input  logic pixel_2,
  input  logic pixel_3,
  input  logic clear_err,
  output logic pool_valid,
  output logic pool_bit,
  max_pool_row_packer_if.master row,
  output logic frame_done,
  output logic overflow
);

  localparam int unsigned XW = $clog2(OUT_W);
  localparam int unsigned YW = $clog2(OUT_H);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
  localparam logic [CW-1:0] FULL   = CW'(FIFO_DEPTH);

  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic [OUT_W-2:0] row_reg;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             row_valid_q;

  logic [OUT_W-1:0] mem_data [FIFO_DEPTH];
  logic [YW-1:0]    mem_idx  [FIFO_DEPTH];

  logic          p_c;
  logic          row_done_c;
  logic          pop_c;
  logic          push_c;
  logic          drop_c;
  logic [CW-1:0] count_next_c;

  // Window reduction and FIFO push/pop/drop decisions
  assign p_c        = pixel_0 | pixel_1 | pixel_2 | pixel_3;
  assign row_done_c = valid_in && (x == X_LAST);
  assign pop_c      = (count != '0) && row.row_ready;
  assign push_c     = row_done_c && ((count != FULL) || pop_c);
  assign drop_c     = row_done_c && !push_c;

  always_comb begin
    count_next_c = count;
    case ({push_c, pop_c})
      2'b10:   count_next_c = count + CW'(1);
      2'b01:   count_next_c = count - CW'(1);
      default: count_next_c = count;
    endcase
  end

  assign row.row_valid = row_valid_q;
  assign row.row_data  = mem_data[rd_ptr];
  assign row.row_idx   = mem_idx[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      row_reg     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      row_valid_q <= 1'b0;
      pool_valid  <= 1'b0;
      pool_bit    <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_idx[i]  <= '0;
      end
    end else begin
      pool_valid <= valid_in;
      pool_bit   <= valid_in & p_c;

      // Row assembly: shift right so column 0 lands in bit 0 at row end
      if (valid_in) begin
        if (x == X_LAST) begin
          x       <= '0;
          row_reg <= '0;
          y       <= (y == Y_LAST) ? '0 : y + YW'(1);
        end else begin
          x       <= x + XW'(1);
          row_reg <= {p_c, row_reg[OUT_W-2:1]};
        end
      end

      if (push_c) begin
        mem_data[wr_ptr] <= {p_c, row_reg};
        mem_idx[wr_ptr]  <= y;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count       <= count_next_c;
      row_valid_q <= (count_next_c != '0);

      frame_done <= pop_c && (mem_idx[rd_ptr] == Y_LAST);

      // A new drop outranks a same-cycle clear
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clear_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_row_packer.sv
// Directed bench for max_pool_row_packer: OR reduction, row packing, FIFO
// backpressure/overflow, full-boundary push+pop, frame_done and mid-row reset.
module tb_max_pool_row_packer;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_in;
  logic pixel_0, pixel_1, pixel_2, pixel_3;
  logic clear_err;
  logic pool_valid, pool_bit;
  logic frame_done, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  always #5 clk = ~clk;

  max_pool_row_packer_if #(.OUT_W(13), .OUT_H(13)) row_bus ();

  max_pool_row_packer #(.OUT_W(13), .OUT_H(13), .FIFO_DEPTH(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pixel_0    (pixel_0),
    .pixel_1    (pixel_1),
    .pixel_2    (pixel_2),
    .pixel_3    (pixel_3),
    .clear_err  (clear_err),
    .pool_valid (pool_valid),
    .pool_bit   (pool_bit),
    .row        (row_bus.master),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of input (window string order pixel_0..pixel_3), return at next negedge
  task automatic drive(input logic v, input logic [3:0] w);
    valid_in = v;
    {pixel_0, pixel_1, pixel_2, pixel_3} = w;
    @(posedge clk);
    @(negedge clk);
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'b0000);
    drive(1'b0, 4'b0000);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0;
    {pixel_0, pixel_1, pixel_2, pixel_3} = 4'b0000;
    clear_err = 1'b0;
    row_bus.row_ready = 1'b1;
    @(negedge clk);
    do_reset();

    check_eq("rst_row_valid",  32'(row_bus.row_valid), 32'd0);
    check_eq("rst_row_data",   32'(row_bus.row_data),  32'd0);
    check_eq("rst_row_idx",    32'(row_bus.row_idx),   32'd0);
    check_eq("rst_pool_valid", 32'(pool_valid),        32'd0);
    check_eq("rst_overflow",   32'(overflow),          32'd0);
    check_eq("rst_frame_done", 32'(frame_done),        32'd0);

    // Single row with ends set
    for (int c = 0; c < 13; c++) begin
      drive(1'b1, (c == 0) ? 4'b0100 : (c == 12) ? 4'b0001 : 4'b0000);
      if (c == 11) check_eq("t1_not_yet_valid", 32'(row_bus.row_valid), 32'd0);
    end
    check_eq("t1_row_valid", 32'(row_bus.row_valid), 32'd1);
    check_eq("t1_row_data",  32'(row_bus.row_data),  32'h1001);
    check_eq("t1_row_idx",   32'(row_bus.row_idx),   32'd0);
    drive(1'b0, 4'b0000);
    check_eq("t1_popped", 32'(row_bus.row_valid), 32'd0);

    // OR semantics with a gap
    drive(1'b1, 4'b0001);
    check_eq("t2_pv0", 32'(pool_valid), 32'd1);
    check_eq("t2_pb0", 32'(pool_bit),   32'd1);
    drive(1'b1, 4'b0010);
    check_eq("t2_pb1", 32'(pool_bit),   32'd1);
    drive(1'b0, 4'b1111);
    check_eq("t2_gap_pv", 32'(pool_valid), 32'd0);
    check_eq("t2_gap_pb", 32'(pool_bit),   32'd0);
    drive(1'b1, 4'b0100);
    check_eq("t2_pb2", 32'(pool_bit),   32'd1);
    drive(1'b1, 4'b1000);
    check_eq("t2_pb3", 32'(pool_bit),   32'd1);
    drive(1'b1, 4'b0000);
    check_eq("t2_pv4", 32'(pool_valid), 32'd1);
    check_eq("t2_pb4", 32'(pool_bit),   32'd0);
    drive(1'b1, 4'b1111);
    check_eq("t2_pb5", 32'(pool_bit),   32'd1);
    for (int c = 6; c < 13; c++) begin
      drive(1'b1, 4'b0000);
      if (c == 11) check_eq("t2_not_yet_valid", 32'(row_bus.row_valid), 32'd0);
    end
    check_eq("t2_row_valid", 32'(row_bus.row_valid), 32'd1);
    check_eq("t2_row_data",  32'(row_bus.row_data),  32'h002F);
    check_eq("t2_row_idx",   32'(row_bus.row_idx),   32'd1);
    drive(1'b0, 4'b0000);

    // Backpressure: row 2 dropped, then drop coinciding with clear_err
    do_reset();
    row_bus.row_ready = 1'b0;
    for (int i = 0; i < 39; i++) begin
      drive(1'b1, 4'b1111);
      if (i == 37) check_eq("t3_no_ovf_yet", 32'(overflow), 32'd0);
    end
    check_eq("t3_overflow",  32'(overflow),          32'd1);
    check_eq("t3_row_valid", 32'(row_bus.row_valid), 32'd1);
    check_eq("t3_row_data",  32'(row_bus.row_data),  32'h1FFF);
    check_eq("t3_row_idx0",  32'(row_bus.row_idx),   32'd0);
    drive(1'b1, 4'b0000);
    clear_err = 1'b1;
    drive(1'b0, 4'b0000);
    check_eq("t3_cleared_once", 32'(overflow), 32'd0);
    for (int i = 1; i < 12; i++) drive(1'b1, 4'b0000);
    drive(1'b1, 4'b1111);
    clear_err = 1'b0;
    check_eq("t3_set_wins", 32'(overflow), 32'd1);
    row_bus.row_ready = 1'b1;
    drive(1'b0, 4'b0000);
    check_eq("t3_head_idx1", 32'(row_bus.row_idx),   32'd1);
    check_eq("t3_head_data", 32'(row_bus.row_data),  32'h1FFF);
    check_eq("t3_valid1",    32'(row_bus.row_valid), 32'd1);
    drive(1'b0, 4'b0000);
    check_eq("t3_empty", 32'(row_bus.row_valid), 32'd0);
    clear_err = 1'b1;
    drive(1'b0, 4'b0000);
    clear_err = 1'b0;
    check_eq("t3_clear", 32'(overflow), 32'd0);

    // Full FIFO, pop on the same edge as the row-2 push
    do_reset();
    row_bus.row_ready = 1'b0;
    for (int i = 0; i < 38; i++) drive(1'b1, 4'b1111);
    check_eq("t4_full_idx", 32'(row_bus.row_idx), 32'd0);
    row_bus.row_ready = 1'b1;
    drive(1'b1, 4'b1111);
    check_eq("t4_no_ovf", 32'(overflow),        32'd0);
    check_eq("t4_idx1",   32'(row_bus.row_idx), 32'd1);
    drive(1'b0, 4'b0000);
    check_eq("t4_idx2",   32'(row_bus.row_idx),   32'd2);
    check_eq("t4_valid2", 32'(row_bus.row_valid), 32'd1);
    drive(1'b0, 4'b0000);
    check_eq("t4_empty",   32'(row_bus.row_valid), 32'd0);
    check_eq("t4_no_ovf2", 32'(overflow),          32'd0);

    // Full frame: row r carries a single 1 at column r
    do_reset();
    fd_cnt = 0;
    for (int r = 0; r < 13; r++) begin
      for (int c = 0; c < 13; c++) drive(1'b1, (c == r) ? 4'b0010 : 4'b0000);
      check_eq($sformatf("t5_idx_r%0d", r),  32'(row_bus.row_idx),  32'(r));
      check_eq($sformatf("t5_data_r%0d", r), 32'(row_bus.row_data), 32'(1) << r);
    end
    check_eq("t5_no_fd_yet", 32'(fd_cnt), 32'd0);
    drive(1'b1, 4'b0000);
    check_eq("t5_frame_done", 32'(frame_done), 32'd1);
    for (int c = 1; c < 13; c++) drive(1'b1, 4'b0000);
    check_eq("t5_fd_count",  32'(fd_cnt),            32'd1);
    check_eq("t5_wrap_idx",  32'(row_bus.row_idx),   32'd0);
    check_eq("t5_wrap_vld",  32'(row_bus.row_valid), 32'd1);

    // Reset mid-row discards the partial row and the pending FIFO entry
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b1111);
    do_reset();
    check_eq("t6_rst_valid", 32'(row_bus.row_valid), 32'd0);
    check_eq("t6_rst_data",  32'(row_bus.row_data),  32'd0);
    check_eq("t6_rst_pv",    32'(pool_valid),        32'd0);
    check_eq("t6_rst_pb",    32'(pool_bit),          32'd0);
    for (int i = 0; i < 13; i++) drive(1'b1, 4'b1000);
    check_eq("t6_valid", 32'(row_bus.row_valid), 32'd1);
    check_eq("t6_idx",   32'(row_bus.row_idx),   32'd0);
    check_eq("t6_data",  32'(row_bus.row_data),  32'h1FFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/max_pool_row_packer.md
Name: max_pool_row_packer

Overview:
- Downstream stage of the 2x2 pooling window buffer.
- Consumes one 2x2 binary window per valid cycle and reduces it to one pooled bit (binary max, i.e. OR).
- Packs pooled bits into row words of the OUT_W x OUT_H pooled feature map and hands completed rows to the dense/readout stage through a small valid/ready FIFO.
- Flags dropped rows and marks end of frame.

Parameters:
- OUT_W, 13, pooled map width (bits per row word).
- OUT_H, 13, pooled map height (rows per frame).
- FIFO_DEPTH, 2, row-word FIFO entries (power of two, >=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid_in  input  1  window valid from pooling buffer.
- pixel_0  input  1  window top-left.
- pixel_1  input  1  window top-right.
- pixel_2  input  1  window bottom-left.
- pixel_3  input  1  window bottom-right.
- clear_err  input  1  synchronous clear of the overflow flag.
- pool_valid  output  1  registered pooled-bit strobe (debug/monitor).
- pool_bit  output  1  registered pooled bit.
- row_valid  output  1  FIFO not empty.
- row_ready  input  1  consumer accepts head row.
- row_data  output  OUT_W  head row word; bit k = column k.
- row_idx  output  $clog2(OUT_H)  row number of head word.
- frame_done  output  1  one-cycle pulse on pop of row OUT_H-1.
- overflow  output  1  sticky: a completed row was dropped.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; x, y, FIFO pointers and count 0; row shift register 0; overflow 0. Any partial row or FIFO content is discarded.
- Pooled bit p = pixel_0 | pixel_1 | pixel_2 | pixel_3, sampled only when valid_in=1.
- pool_valid/pool_bit are registered with 1-cycle latency. When valid_in=0, pool_valid=0 and pool_bit=0 next cycle.
- Column counter x (0..OUT_W-1) and row counter y (0..OUT_H-1) advance only on valid_in=1. Both hold through any gaps in valid_in.
- Each valid_in writes p into row_reg[x].
- When x==OUT_W-1 (row complete):
  - Row word {p, row_reg[OUT_W-2:0]} is pushed with tag y, in the same edge.
  - x<=0 and row_reg<=0.
  - y increments, wrapping OUT_H-1 -> 0.
- Latency: a pushed row appears at row_valid/row_data on the cycle after the edge that sampled its last valid_in.
- FIFO:
  - row_valid = (count!=0). row_data and row_idx always show the head entry, and hold stable while row_valid=1 and row_ready=0.
  - Pop happens on row_valid & row_ready at the rising edge.
  - Push succeeds when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop occurs in the same cycle. A simultaneous push and pop leaves count unchanged.
  - Push with FIFO full and no pop: the row is dropped, overflow<=1, and x/y still advance so frame alignment is kept.
  - Pop with FIFO empty is ignored.
- overflow:
  - Sticky until clear_err=1 or reset.
  - clear_err in the same cycle as a new drop leaves overflow=1 (set wins).
- frame_done: registered one-cycle pulse in the cycle after the pop of an entry whose row_idx==OUT_H-1. If that row was dropped, frame_done does not fire.
- Counter widths are $clog2(OUT_W) and $clog2(OUT_H). FIFO count width is $clog2(FIFO_DEPTH)+1.

Test Plan:
- Single row, row_ready=1: 13 windows, all 0000 except window 0 = 0100 and window 12 = 0001 -> row_valid=1 one cycle after the 13th valid_in, row_data=13'h1001, row_idx=0.
- OR semantics: windows 0001, 0010, 0100, 1000, 0000, 1111, with a valid_in gap between the 2nd and 3rd -> pool_bit sequence 1,1,1,1,0,1, each 1 cycle after its input; pool_valid=0 during the gap; x unaffected by the gap.
- Backpressure, row_ready=0: 3 full rows of all-1 windows -> FIFO holds rows 0 and 1 (13'h1FFF), row 2 dropped, overflow=1. Then row_ready=1 -> pops idx 0, then idx 1, then row_valid=0. Then clear_err=1 -> overflow=0.
- Full-boundary push/pop, FIFO full: raise row_ready in the same cycle row 2 completes -> no drop, overflow stays 0, rows 0, 1, 2 delivered in order.
- Full frame, row_ready=1: 169 windows -> 13 rows with idx 0..12 and a single frame_done pulse after the idx-12 pop. The next 13 windows produce row_idx=0.
- Reset mid-row: 5 windows, then rst_n=0 for 2 cycles -> all outputs 0. The next 13 windows (all 1000) produce row_idx=0, row_data=13'h1FFF.
